// File: rtl/uart_word_rx.sv
// UART receiver with tick divider, oversampling FSM and multi-byte word assembler.
// Define UART_PARITY_EN to add a parity bit between the data and stop bits.
module uart_word_rx #(
  parameter int unsigned CLK_DIV        = 32,
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned D_BIT          = 8,
  parameter int unsigned SB_TICK        = 16,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned PARITY_ODD     = 0,
  parameter int unsigned CNT_W          = 14
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            rx_data_i,
  input  logic                            word_ready_i,
  output logic                            word_valid_o,
  output logic [D_BIT*BYTES_PER_WORD-1:0] word_data_o,
  output logic                            frame_err_o,
  output logic                            parity_err_o,
  output logic                            overrun_o,
  output logic [CNT_W-1:0]                byte_count_o,
  output logic [CNT_W-1:0]                err_count_o
);

  localparam int unsigned WORD_W   = D_BIT * BYTES_PER_WORD;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned S_MAX    = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned S_W      = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int unsigned N_W      = (D_BIT > 1) ? $clog2(D_BIT) : 1;
  localparam int unsigned IDX_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned LAST_IDX = BYTES_PER_WORD - 1;

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_e;

  logic             rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0] div_q;
  logic             tick_c;

  state_e           state_q, state_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [D_BIT-1:0] sh_q, sh_d;
  logic [D_BIT:0]   sh_ext_c;
  logic             par_q, par_d;
  logic             par_exp_c;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;

  logic [WORD_W-1:0] asm_q, word_c, word_data_q;
  logic [IDX_W-1:0]  idx_q;
  logic              word_valid_q, overrun_q, last_c, free_c;
  logic [CNT_W-1:0]  byte_count_q, err_count_q;

  // Two-flop synchroniser; idle level is high so it resets to 1.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_data_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) div_q <= '0;
    else         div_q <= tick_c ? '0 : div_q + DIV_W'(1);
  end

  assign sh_ext_c  = {rx_sync_q, sh_q};
  assign par_exp_c = (^sh_q) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    par_d   = par_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (s_q == S_W'(OVERSAMPLE / 2 - 1)) begin
            if (!rx_sync_q) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (s_q == S_W'(OVERSAMPLE - 1)) begin
            sh_d = sh_ext_c[D_BIT:1];
            s_d  = '0;
            if (n_q == N_W'(D_BIT - 1)) state_d = PAR_EN ? ST_PARITY : ST_STOP;
            else                        n_d = n_q + N_W'(1);
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick_c) begin
          if (s_q == S_W'(OVERSAMPLE - 1)) begin
            par_d   = rx_sync_q;
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_STOP: begin
        // A low stop bit wins over a parity mismatch so each bad frame counts once.
        if (tick_c) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            s_d = '0;
            if (rx_sync_q) begin
              if (PAR_EN && (par_q != par_exp_c)) perr_d = 1'b1;
              else                                done_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating debug counters, updated alongside the registered pulses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      byte_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      if (done_d && !(&byte_count_q))           byte_count_q <= byte_count_q + CNT_W'(1);
      if ((ferr_d || perr_d) && !(&err_count_q)) err_count_q <= err_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    word_c = asm_q;
    word_c[idx_q*D_BIT +: D_BIT] = sh_q;
  end

  assign last_c = (idx_q == IDX_W'(LAST_IDX));
  assign free_c = !word_valid_q || word_ready_i;

  // A word completing while the output is still held is dropped, not queued.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      asm_q        <= '0;
      idx_q        <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (done_q && last_c && free_c) begin
        word_data_q  <= word_c;
        word_valid_q <= 1'b1;
      end else if (word_valid_q && word_ready_i) begin
        word_valid_q <= 1'b0;
      end
      if (done_q) begin
        if (last_c) begin
          idx_q <= '0;
          if (!free_c) overrun_q <= 1'b1;
        end else begin
          asm_q <= word_c;
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_data_o  = word_data_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_q;
  assign overrun_o    = overrun_q;
  assign byte_count_o = byte_count_q;
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed and randomized bench for uart_word_rx with a queue-based word model.
module tb_uart_word_rx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned D_BIT      = 8;
  localparam int unsigned SB_TICK    = 16;
  localparam int unsigned BPW        = 4;
  localparam int unsigned PARITY_ODD = 0;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned BIT        = CLK_DIV * OVERSAMPLE;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_data;
  logic             word_ready;
  logic             word_valid;
  logic [31:0]      word_data;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;
  logic [CNT_W-1:0] byte_count;
  logic [CNT_W-1:0] err_count;

  uart_word_rx #(
    .CLK_DIV(CLK_DIV), .OVERSAMPLE(OVERSAMPLE), .D_BIT(D_BIT), .SB_TICK(SB_TICK),
    .BYTES_PER_WORD(BPW), .PARITY_ODD(PARITY_ODD), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .reset_i(reset), .rx_data_i(rx_data), .word_ready_i(word_ready),
    .word_valid_o(word_valid), .word_data_o(word_data), .frame_err_o(frame_err),
    .parity_err_o(parity_err), .overrun_o(overrun), .byte_count_o(byte_count),
    .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  lanes[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int good_n, bad_n, fbad_n, pbad_n;
  int fe_hi, pe_hi;

  // Observer: accepted words and error-pulse high cycles.
  always @(negedge clk) begin
    if (!reset) begin
      if (word_valid && word_ready) got_q.push_back(word_data);
      if (frame_err)  fe_hi++;
      if (parity_err) pe_hi++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_data = v;
    step(BIT);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [31:0] w;
    if (good) begin
      good_n++;
      lanes.push_back(b);
      if (lanes.size() == BPW) begin
        w = 32'h0;
        for (int i = 0; i < BPW; i++) w = w | (32'(lanes[i]) << (8 * i));
        exp_q.push_back(w);
        lanes.delete();
      end
    end else begin
      bad_n++;
    end
  endtask

  task automatic model_reset();
    lanes.delete();
    exp_q.delete();
    got_q.delete();
    good_n = 0; bad_n = 0; fbad_n = 0; pbad_n = 0;
    fe_hi = 0; pe_hi = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
    drive_bit((^b) ^ (PARITY_ODD != 0));
`endif
    drive_bit(stop_ok);
    if (!stop_ok) begin
      drive_bit(1'b1);
      fbad_n++;
    end
    model_byte(b, stop_ok);
  endtask

`ifdef UART_PARITY_EN
  task automatic send_par_frame(input logic [7:0] b, input logic par);
    bit ok;
    ok = (par == ((^b) ^ (PARITY_ODD != 0)));
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(1'b1);
    if (!ok) pbad_n++;
    model_byte(b, ok);
  endtask
`endif

  task automatic check_counts(input string tag);
    check({tag, "_byte_count"}, 64'(byte_count), 64'(sat(good_n)));
    check({tag, "_err_count"},  64'(err_count),  64'(sat(bad_n)));
  endtask

  task automatic check_words(input string tag);
    int n;
    check({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  64'(word_valid), 64'h0);
    check({tag, "_data"},   64'(word_data),  64'h0);
    check({tag, "_ferr"},   64'(frame_err),  64'h0);
    check({tag, "_perr"},   64'(parity_err), 64'h0);
    check({tag, "_ovr"},    64'(overrun),    64'h0);
    check({tag, "_bcnt"},   64'(byte_count), 64'h0);
    check({tag, "_ecnt"},   64'(err_count),  64'h0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    bit          ok;

    reset = 1'b1; rx_data = 1'b1; word_ready = 1'b1;
    model_reset();
    step(5);
    check_reset_outputs("rst");
    reset = 1'b0;
    step(2 * BIT);

    // Four good bytes make one word, first byte in the low lane.
    send_frame(8'h12, 1'b1); send_frame(8'h34, 1'b1);
    send_frame(8'h56, 1'b1); send_frame(8'h78, 1'b1);
    w = (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx;
    check("t1_word_const", 64'(w), 64'h78563412);
    check_words("t1");
    check_counts("t1");
    check("t1_valid_dropped", 64'(word_valid), 64'h0);

    // Framing error discards the byte and leaves the lane index alone.
    send_frame(8'hA5, 1'b0);
    send_frame(8'h11, 1'b1);
    check("t2_fe_cycles", 64'(fe_hi), 64'(fbad_n));
    check_counts("t2");
    for (int i = 0; i < 3; i++) send_frame(8'(8'h20 + i), 1'b1);
    w = (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx;
    check("t2_lane0", 64'(w[7:0]), 64'h11);
    check_words("t2");

    // Short glitch on the line is rejected at the start-bit midpoint.
    rx_data = 1'b0;
    step(4 * CLK_DIV);
    rx_data = 1'b1;
    step(2 * BIT);
    check_counts("t3");
    check("t3_fe_cycles", 64'(fe_hi), 64'(fbad_n));
    check_words("t3");

    // Held output: second word is dropped and overrun latches.
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
    check("t4_valid", 64'(word_valid), 64'h1);
    check("t4_data",  64'(word_data),  64'h03020100);
    check("t4_ovr",   64'(overrun),    64'h1);
    check_counts("t4");
    exp_q.delete();
    word_ready = 1'b1;
    step(1);
    word_ready = 1'b0;
    step(3);
    check("t4_valid_after_ack", 64'(word_valid), 64'h0);
    check("t4_acked_n", 64'(got_q.size()), 64'h1);
    w = (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx;
    check("t4_acked_word", 64'(w), 64'h03020100);
    got_q.delete();
    for (int i = 8; i < 12; i++) send_frame(8'(i), 1'b1);
    check("t4_data2", 64'(word_data), 64'h0B0A0908);
    check("t4_valid2", 64'(word_valid), 64'h1);
    check("t4_ovr_sticky", 64'(overrun), 64'h1);
    exp_q.delete();
    word_ready = 1'b1;
    step(3);
    w = (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx;
    check("t4_acked_word2", 64'(w), 64'h0B0A0908);
    got_q.delete();

    // Random bytes with occasional bad stop bits against the model.
    for (int k = 0; k < 16; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      if ($urandom_range(0, 2) == 0) step($urandom_range(1, BIT));
    end
    check_words("rnd");
    check_counts("rnd");
    check("rnd_fe_cycles", 64'(fe_hi), 64'(fbad_n));
    check("rnd_pe_cycles", 64'(pe_hi), 64'(pbad_n));

`ifdef UART_PARITY_EN
    send_par_frame(8'h03, 1'b1);
    check("par_pe_cycles", 64'(pe_hi), 64'(pbad_n));
    check_counts("par_bad");
    send_par_frame(8'h03, 1'b0);
    check_counts("par_good");
    check("par_pe_cycles2", 64'(pe_hi), 64'(pbad_n));
`endif

    // Reset mid-frame, then a clean word.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx_data = 1'b1;
    step(BIT / 2);
    reset = 1'b1;
    step(3);
    check_reset_outputs("t6");
    model_reset();
    reset = 1'b0;
    step(2 * BIT);
    for (int i = 0; i < 4; i++) send_frame(8'h5A, 1'b1);
    w = (got_q.size() > 0) ? got_q[0] : 32'hxxxxxxxx;
    check("t6_word_const", 64'(w), 64'h5A5A5A5A);
    check_words("t6");
    check_counts("t6");
    check("t6_ovr", 64'(overrun), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
